// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// ----------------------------------------------------------------------------
// Read-side output stage of the asynchronous FIFO. It issues read enables
// against the registered empty flag and captures the memory's registered read
// data into a 2-entry buffer. The buffered data leaves as a
// first-word-fall-through valid/ready stream. The block also reports a
// conservative read-domain fill level.
//
// Ports
//   rclock          read-domain clock
//   rreset          asynchronous active-low reset
//   empty           registered empty flag from the read-pointer stage
//   bin_rptr        binary read pointer (post-increment, registered)
//   gray_wptr_sync  gray write pointer, already synchronised into rclock
//   r_en            read request; a read is accepted on r_en & !empty
//   rdata           memory read data, valid one rclock after an accepted read
//   m_valid/m_data  output stream (head of the buffer)
//   m_ready         downstream accept
//   rd_level        registered words available: FIFO body + in-flight + buffered
//   dbg_state       buffer FSM state (number of entries held)
//
// Handshake: a word transfers on every rclock edge where m_valid & m_ready.
// While m_valid is high and m_ready is low, m_valid and m_data hold their
// values. m_valid never depends on m_ready.
// ----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  rclock,
  input  logic                  rreset,
  input  logic                  empty,
  input  logic [PTR_WIDTH:0]    bin_rptr,
  input  logic [PTR_WIDTH:0]    gray_wptr_sync,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [PTR_WIDTH+1:0]  rd_level,
  output logic [1:0]            dbg_state
);

  // The state encoding is the number of buffered entries, so the state doubles
  // as the occupancy count.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } buf_state_t;

  buf_state_t state;
  buf_state_t state_next;

  logic                  infl;
  logic                  pop;
  logic                  acc;
  logic [1:0]            occ;
  logic [2:0]            occ_after;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [PTR_WIDTH:0]    wbin;
  logic [PTR_WIDTH:0]    body;
  logic [PTR_WIDTH+1:0]  level_next;

  assign occ       = state;
  assign dbg_state = state;
  assign pop       = m_valid & m_ready;
  assign acc       = r_en & !empty;

  // Occupancy once this cycle's arrival and departure have settled. A read is
  // only issued when that value leaves room. Data returned next cycle therefore
  // always finds a free slot, even if the consumer stalls.
  assign occ_after = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge rclock or negedge rreset) begin
    if (!rreset) begin
      state <= B0;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      B0: begin
        if (infl) state_next = B1;
      end
      B1: begin
        if (infl && !pop)      state_next = B2;
        else if (pop && !infl) state_next = B0;
      end
      B2: begin
        // The credit rule keeps infl low here, so only a pop moves us.
        if (pop) state_next = B1;
      end
      default: state_next = B0;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    m_valid = (state != B0);
    r_en    = rreset & !empty & (occ_after < 3'd2);
  end

  // In-flight flag: the memory returns data exactly one cycle after acceptance.
  always_ff @(posedge rclock or negedge rreset) begin
    if (!rreset) begin
      infl <= 1'b0;
    end else begin
      infl <= acc;
    end
  end

  // Two-entry buffer. buf0 is always the head (oldest word) and buf1 is only
  // used in B2. When B1 pops and a word arrives in the same cycle, the arrival
  // goes straight into the head slot.
  always_ff @(posedge rclock or negedge rreset) begin
    if (!rreset) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case (state)
        B0: begin
          if (infl) buf0 <= rdata;
        end
        B1: begin
          if (infl && pop) buf0 <= rdata;
          else if (infl)   buf1 <= rdata;
        end
        B2: begin
          if (pop) buf0 <= buf1;
        end
        default: begin
          buf0 <= buf0;
        end
      endcase
    end
  end

  assign m_data = buf0;

  // Gray to binary: each bit is the XOR of all gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      wbin[i] = ^(gray_wptr_sync >> i);
    end
  end

  // The subtraction wraps naturally across the extra pointer bit. A lagging
  // synchronised write pointer can only make body smaller, never larger.
  assign body       = wbin - bin_rptr;
  assign level_next = {1'b0, body}
                    + {{(PTR_WIDTH + 1){1'b0}}, infl}
                    + {{PTR_WIDTH{1'b0}}, occ};

  always_ff @(posedge rclock or negedge rreset) begin
    if (!rreset) begin
      rd_level <= '0;
    end else begin
      rd_level <= level_next;
    end
  end

  // Arriving data must never find the buffer full.
  assert property (@(posedge rclock) disable iff (!rreset)
    !(infl && (state == B2) && !pop));

  // A stalled output word must stay put until it is accepted.
  assert property (@(posedge rclock) disable iff (!rreset)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. A small model of the FIFO body (memory,
// binary pointers, registered empty) drives the DUT inputs. A scoreboard
// (exp_q) holds every word written and checks pop order. rd_level is checked
// every cycle against the count written minus the count popped, taken one
// cycle earlier.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam int LW = PW + 2;

  // ---------------- clock / reset ----------------
  logic rclock = 1'b0;
  logic rreset;
  always #5 rclock = ~rclock;

  logic          empty;
  logic [PW:0]   bin_rptr;
  logic [PW:0]   gray_wptr_sync;
  logic          r_en;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [LW-1:0] rd_level;
  logic [1:0]    dbg_state;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
    .rclock        (rclock),
    .rreset        (rreset),
    .empty         (empty),
    .bin_rptr      (bin_rptr),
    .gray_wptr_sync(gray_wptr_sync),
    .r_en          (r_en),
    .rdata         (rdata),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rd_level      (rd_level),
    .dbg_state     (dbg_state)
  );

  // ---------------- FIFO model + scoreboard ----------------
  logic [DW-1:0] mem [0:7];
  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  int            wtot;
  int            ptot;
  int            wr_cap;
  int            acc_cnt;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_q[$];
  logic [LW-1:0] lvl_exp;
  logic          hold_pend;
  logic [DW-1:0] hold_data;

  int errors = 0;
  int checks = 0;

  function automatic logic [PW:0] bin2gray(input logic [PW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic refresh();
    bin_rptr       = rptr;
    gray_wptr_sync = bin2gray(wptr);
    empty          = (rptr == wptr);
  endtask

  task automatic model_reset();
    rptr      = '0;
    wptr      = '0;
    wtot      = 0;
    ptot      = 0;
    wr_cap    = 8;
    lvl_exp   = '0;
    hold_pend = 1'b0;
    hold_data = '0;
    rdata     = '0;
    exp_q.delete();
    pend_q.delete();
    refresh();
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    mem[wptr[PW-1:0]] = d;
    wptr = wptr + 1'b1;
    wtot++;
    exp_q.push_back(d);
    refresh();
  endtask

  // ---------------- driver: one rclock cycle ----------------
  // Starts in the low phase. Samples the DUT, scores any pop, then advances the
  // model at the edge.
  task automatic step(input logic rdy);
    logic          acc;
    logic [DW-1:0] exp_w;
    m_ready = rdy;
    #1;
    checks++;
    if (rd_level !== lvl_exp) begin
      errors++;
      $display("FAIL rd_level: got %0d expected %0d", rd_level, lvl_exp);
    end
    if (hold_pend) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== hold_data) begin
        errors++;
        $display("FAIL hold_stable: got valid=%b data=%0h expected valid=1 data=%0h",
                 m_valid, m_data, hold_data);
      end
    end
    hold_pend = m_valid & !m_ready;
    hold_data = m_data;
    lvl_exp   = LW'(wtot - ptot);
    acc       = r_en & !empty;
    if (acc) acc_cnt++;
    if (m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_extra: got data=%0h expected no word", m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin
          errors++;
          $display("FAIL pop_order: got %0h expected %0h", m_data, exp_w);
        end
      end
      ptot++;
    end
    @(posedge rclock);
    #1;
    if (acc) begin
      rdata = mem[rptr[PW-1:0]];
      rptr  = rptr + 1'b1;
    end
    refresh();
    if (pend_q.size() > 0 && (wtot - ptot) < wr_cap) load_word(pend_q.pop_front());
    @(negedge rclock);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && pend_q.size() == 0 && !m_valid && empty) break;
      step(1'b1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words left expected 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rreset = 1'b0;
    m_ready = 1'b0;
    model_reset();
    load_word(8'h55);
    @(negedge rclock);
    @(negedge rclock);
    #1;
    checks++;
    if (r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b expected 0", r_en); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
    checks++;
    if (rd_level !== 5'd0) begin errors++; $display("FAIL reset_rd_level: got %0d expected 0", rd_level); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rreset = 1'b1;
    #1;
    checks++;
    if (r_en !== 1'b1) begin errors++; $display("FAIL release_r_en: got %b expected 1", r_en); end
    drain(12);
    checks++;
    if (ptot != 1) begin errors++; $display("FAIL reset_words: got %0d expected 1", ptot); end
  endtask

  task automatic test_streaming();
    int first_v;
    int last_v;
    int vcnt;
    int p0;
    first_v = -1;
    last_v  = -1;
    vcnt    = 0;
    p0      = ptot;
    for (int k = 0; k < 8; k++) load_word(8'h10 + 8'(k));
    for (int i = 0; i < 14; i++) begin
      m_ready = 1'b1;
      #1;
      if (i == 0) begin
        checks++;
        if (r_en !== 1'b1) begin errors++; $display("FAIL stream_first_r_en: got %b expected 1", r_en); end
      end
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        vcnt++;
      end
      step(1'b1);
    end
    checks++;
    if (first_v != 2) begin errors++; $display("FAIL stream_latency: got %0d expected 2", first_v); end
    checks++;
    if (vcnt != 8 || last_v != first_v + 7) begin
      errors++;
      $display("FAIL stream_gapless: got count=%0d last=%0d expected count=8 last=%0d", vcnt, last_v, first_v + 7);
    end
    checks++;
    if (ptot - p0 != 8) begin errors++; $display("FAIL stream_words: got %0d expected 8", ptot - p0); end
    drain(4);
  endtask

  task automatic test_back_pressure();
    int p0;
    p0 = ptot;
    for (int k = 0; k < 8; k++) load_word(8'h10 + 8'(k));
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) step(1'b0);
    checks++;
    if (acc_cnt != 2) begin errors++; $display("FAIL bp_reads: got %0d expected 2", acc_cnt); end
    checks++;
    if (dbg_state !== 2'd2) begin errors++; $display("FAIL bp_state: got %0d expected 2", dbg_state); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h10) begin
      errors++;
      $display("FAIL bp_head: got valid=%b data=%0h expected valid=1 data=10", m_valid, m_data);
    end
    checks++;
    if (rd_level !== 5'd8) begin errors++; $display("FAIL bp_level: got %0d expected 8", rd_level); end
    m_ready = 1'b1;
    #1;
    checks++;
    if (r_en !== 1'b1) begin errors++; $display("FAIL bp_resume_r_en: got %b expected 1", r_en); end
    drain(20);
    checks++;
    if (ptot - p0 != 8) begin errors++; $display("FAIL bp_words: got %0d expected 8", ptot - p0); end
  endtask

  task automatic test_simultaneous();
    int p0;
    p0 = ptot;
    for (int k = 0; k < 5; k++) load_word(8'(k));
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      step((i % 2) == 0);
    end
    drain(8);
    checks++;
    if (ptot - p0 != 5) begin errors++; $display("FAIL simul_words: got %0d expected 5", ptot - p0); end
  endtask

  task automatic test_wrap();
    int p0;
    p0 = ptot;
    wr_cap = 6;
    for (int k = 0; k < 40; k++) pend_q.push_back(8'(k * 7 + 3));
    for (int i = 0; i < 300; i++) begin
      if (ptot - p0 >= 40) break;
      step((i % 4) != 3);
    end
    drain(10);
    wr_cap = 8;
    checks++;
    if (ptot - p0 != 40) begin errors++; $display("FAIL wrap_words: got %0d expected 40", ptot - p0); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) load_word(8'h30 + 8'(k));
    step(1'b0);
    step(1'b0);
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_pre_state: got %0d expected 1", dbg_state); end
    rreset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b expected 0", m_valid); end
    checks++;
    if (rd_level !== 5'd0) begin errors++; $display("FAIL mid_rd_level: got %0d expected 0", rd_level); end
    model_reset();
    for (int k = 0; k < 3; k++) load_word(8'hA0 + 8'(k));
    @(negedge rclock);
    #1;
    checks++;
    if (r_en !== 1'b0) begin errors++; $display("FAIL mid_r_en: got %b expected 0", r_en); end
    rreset = 1'b1;
    drain(12);
    checks++;
    if (ptot != 3) begin errors++; $display("FAIL mid_words: got %0d expected 3", ptot); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    acc_cnt = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
